// File: rtl/mux2_arbiter_pkg.sv
// Shared types and helpers for the two-requester packet arbiter.
package mux2_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

  // Owner choice from a pair of requests; prio breaks ties (0 = A, 1 = B).
  function automatic arb_state_t pick_owner(input logic av, input logic bv, input logic p);
    if (av && (!bv || !p)) return OWN_A;
    else if (bv)           return OWN_B;
    else                   return IDLE;
  endfunction

endpackage

// File: rtl/mux2.sv
// Gated two-input word mux: y is zero when disabled.
module mux2 #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sel,
  input  logic         enable,
  output logic [N-1:0] y
);

  assign y = enable ? (sel ? b : a) : '0;

endmodule

// File: rtl/mux2_arbiter.sv
// Packet-aware round-robin arbiter sharing one mux2 between streams A and B.
//
// state | meaning
// IDLE  | no owner, arbitrate among current valids
// OWN_A | A owns the output until its last beat transfers
// OWN_B | B owns the output until its last beat transfers
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  input  logic [N-1:0] a_data,
  input  logic         a_last,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [N-1:0] b_data,
  input  logic         b_last,
  output logic         b_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic [1:0]   grant
);

  arb_state_t   state, state_nxt;
  logic         prio, prio_nxt;
  logic [N-1:0] mux_y;

  mux2 #(.N(N)) u_mux2 (
    .a      (a_data),
    .b      (b_data),
    .sel    (state == OWN_B),
    .enable (state != IDLE),
    .y      (mux_y)
  );

  assign out_data = mux_y & {N{out_valid}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    out_valid = 1'b0;
    out_last  = 1'b0;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    grant     = GRANT_NONE;
    case (state)
      IDLE: begin
        state_nxt = pick_owner(a_valid, b_valid, prio);
      end
      OWN_A: begin
        grant     = GRANT_A;
        out_valid = a_valid;
        out_last  = a_last & a_valid;
        a_ready   = out_ready;
        // Finishing source is masked so the other side gets the next packet.
        if (a_valid && a_last && out_ready) begin
          prio_nxt  = 1'b1;
          state_nxt = pick_owner(1'b0, b_valid, 1'b1);
        end
      end
      OWN_B: begin
        grant     = GRANT_B;
        out_valid = b_valid;
        out_last  = b_last & b_valid;
        b_ready   = out_ready;
        if (b_valid && b_last && out_ready) begin
          prio_nxt  = 1'b0;
          state_nxt = pick_owner(a_valid, 1'b0, 1'b0);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Two-requester, packet-aware round-robin arbiter that shares one `mux2` datapath between two streaming sources (A and B). It owns the mux `sel`/`enable` controls and presents a single valid/ready output stream. A grant is held for a whole packet, ending at the beat flagged `last`, so packets from A and B never interleave. It sits between two producer blocks and one downstream consumer of N-bit words.

## Interface
Parameters:
- `N`, 16, data width in bits.

Ports:
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `a_valid`  input  1  requester A has a beat on `a_data`.
- `a_data`  input  N  requester A data beat.
- `a_last`  input  1  current A beat is the final beat of its packet.
- `a_ready`  output  1  A beat accepted this cycle.
- `b_valid`, `b_data`, `b_last`, `b_ready`: same as the A ports, for requester B.
- `out_valid`  output  1  arbitrated beat present on `out_data`.
- `out_data`  output  N  arbitrated beat; all zero whenever `out_valid` is 0.
- `out_last`  output  1  forwarded `last` of the owning requester, gated by `out_valid`.
- `out_ready`  input  1  downstream accepts the beat.
- `grant`  output  2  one-hot owner: bit0 = A, bit1 = B; 00 when idle.

## Operation
- States:
  - IDLE: no owner.
  - OWN_A: `grant` = 01, mux `sel` = 0.
  - OWN_B: `grant` = 10, mux `sel` = 1.
- Mux control: `enable` = 1 in OWN_A/OWN_B, 0 in IDLE.
- Request: a requester's `*_valid` is its request. Once raised, a source holds `*_valid` and its data stable until that beat transfers.
- Priority pointer `prio`: 0 means A wins a tie, 1 means B wins.
  - Reset value: 0.
  - After a completed A packet, `prio` becomes 1. After a completed B packet, `prio` becomes 0.
- IDLE transitions:
  - Only one valid: go to that owner.
  - Both valid: go to the owner selected by `prio`.
  - Neither valid: stay in IDLE.
- Outputs while owning X:
  - `out_valid` = `x_valid`.
  - `out_data` = `x_data`.
  - `out_last` = `x_last` & `x_valid`.
  - `x_ready` = `out_ready`.
  - The non-owner's ready is 0.
- Transfer: `out_valid` & `out_ready` in the same cycle.
- End of packet, on a transfer with `out_last` = 1:
  - `prio` updates.
  - Next state is chosen by the IDLE rules using the post-update `prio`, from the current cycle's valids, with the finishing source's valid treated as 0.
  - Result: back-to-back packets from different sources need no idle cycle.
  - The same source cannot re-win on the cycle it finishes.
- Non-last transfer, or owner `valid` low: stay in the current state. The owner may pause mid-packet indefinitely.
- Outputs in IDLE: `out_valid` = 0, `out_data` = 0, `out_last` = 0, both readies 0.
- Reset mid-packet:
  - Ownership is dropped on the next edge: state IDLE, `prio` = 0.
  - No partial packet continuation is tracked.

## Timing
- Reset values: state IDLE, `grant` = 00, `prio` = 0, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `a_ready` = 0, `b_ready` = 0.
- Arbitration latency: one cycle.
  - A valid first seen in IDLE at cycle t gives `grant` at t+1.
  - The first transfer is possible at t+1.
- Datapath is combinational while owned:
  - `out_*` follow the owner's inputs in the same cycle.
  - `*_ready` follows `out_ready` in the same cycle.
- Throughput: one beat per cycle while the owner is valid and `out_ready` is high.
- Handover: last beat at cycle t with the other source valid gives the new `grant` at t+1.
- `grant`, state and `prio` are registered. All other outputs are combinational decodes of state plus inputs.

## Structure
- Package `mux2_arbiter_pkg` holds:
  - the state enum `arb_state_t` (IDLE, OWN_A, OWN_B);
  - the constants `GRANT_NONE`, `GRANT_A`, `GRANT_B`.
- Exactly one sub-module: the existing `mux2` (width N).
  - Connect `a` = `a_data`, `b` = `b_data`, `sel` = (state == OWN_B), `enable` = (state != IDLE).
  - Its `y` is ANDed with `out_valid` to form `out_data`.
- Single FSM process plus one combinational next-state/output block; no other storage.

## Test plan
All scenarios use N = 16.
- Reset: `rst` = 1 for 2 cycles with both valids high → `grant` = 00, `out_valid` = 0, `out_data` = 0x0000. After release, `grant` = 01 one cycle later.
- Single source: A sends a 3-beat packet 0x000F, 0x00F0, 0x0F00 (last on the 3rd) with `out_ready` = 1 → `out_data` shows the three beats on consecutive cycles. `out_last` is high only on 0x0F00. `grant` returns to 00 the cycle after.
- Tie and round-robin: both valid from IDLE after reset → A granted first. A's 2-beat packet ends and B is granted the very next cycle with no gap. A's next packet follows B's. `prio` alternates 0 → 1 → 0.
- Backpressure and pause:
  - `out_ready` low for 3 cycles mid-packet → `a_ready` = 0 and 0x00F0 held on `out_data`.
  - A drops `a_valid` mid-packet while B is valid → `grant` stays 01, `out_valid` = 0, `b_ready` = 0.
- Reset mid-packet: assert `rst` after beat 1 of a B packet → next cycle `grant` = 00, `prio` = 0. With both valid afterwards, A wins.
